mult16x16_arb: RTL and testbench
================================

# mult16x16_arb

Round-robin scheduler that shares one fixed-latency `mult16x16` datapath among `NREQ` requesters. It accepts at most one operand pair per cycle through per-requester valid/ready handshakes and drives the registered operands and sign flags into the multiplier. It carries the requester tag alongside each operation through a latency-matched pipeline and returns each product to the issuing requester with a one-hot valid. It sits between the client blocks and the single multiplier instance.

## Interface

**Parameters**

- `NREQ`, default 4: number of requesters, 2..8.
- `MULT_LAT`, default 2: multiplier latency in cycles; `i_product` in cycle t reflects the operands driven in cycle t-`MULT_LAT`. Must be ≥ 1.

**Ports**

- `i_clk` input 1: single clock; all logic on rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_en` input 1: grant enable; 0 blocks new grants, while in-flight operations still complete.
- `i_req_valid` input NREQ: request valid, one bit per requester.
- `o_req_ready` output NREQ: one-hot grant; the request is accepted when `i_req_valid[k] & o_req_ready[k]`.
- `i_req_multa` input NREQ*16: operand A; requester k occupies bits [16k+15:16k].
- `i_req_multb` input NREQ*16: operand B, same packing as operand A.
- `i_req_multa_ns` input NREQ: operand A sign flag per requester; passed to the multiplier unchanged.
- `i_req_multb_ns` input NREQ: operand B sign flag per requester; passed to the multiplier unchanged.
- `o_multa`, `o_multb` output 16 each: registered operands to the multiplier.
- `o_multa_ns`, `o_multb_ns` output 1 each: registered sign flags to the multiplier.
- `i_product` input 32: multiplier result.
- `o_rsp_valid` output NREQ: one-hot response valid. Responses have no backpressure, so the requester must accept in that cycle.
- `o_rsp_product` output 32: registered product, shared by all requesters.
- `o_busy` output 1: 1 while any accepted operation has not yet produced its response.

## Operation

**Arbitration**
- Combinational round-robin arbitration over `i_req_valid`.
- Priority starts at pointer `ptr` and wraps from `NREQ-1` back to 0.
- `o_req_ready` has at most one bit set, and only when `i_en=1` and that requester's valid is 1. It is 0 otherwise.
- `ptr` becomes (granted index + 1) mod `NREQ` on a grant. It is unchanged when there is no grant.

**Issue stage**
- On a grant, the granted requester's A/B operands and sign flags are registered into `o_multa`, `o_multb`, `o_multa_ns` and `o_multb_ns`.
- A stage-valid bit is set together with the tag (granted index).
- With no grant, the operand registers hold their values and the stage-valid bit is 0.

**Tag pipeline**
- Valid and tag shift through `MULT_LAT` stages, aligned with the multiplier.
- When the last stage is valid, `o_rsp_product` <= `i_product` and `o_rsp_valid` <= onehot(tag).
- Otherwise `o_rsp_valid` <= 0 and `o_rsp_product` holds its value.

**Other rules**
- No arithmetic in this block. Product width and signedness are entirely those of the multiplier.
- `o_busy` = OR of the issue-stage valid and all tag-pipeline valids.
- Requesters may hold valid across cycles. An unaccepted request must keep its operands stable. An accepted request takes effect once per valid&ready cycle.

## Timing

- Reset values: `o_req_ready`=0 (because `i_rst` forces no grant), `o_multa`=`o_multb`=0, `o_multa_ns`=`o_multb_ns`=0, `o_rsp_valid`=0, `o_rsp_product`=0, `o_busy`=0, `ptr`=0, all pipeline valids 0.
- Throughput: one accepted request per cycle, sustained.
- Latency from acceptance in cycle T:
  - operands on the `o_mult*` ports in cycle T+1;
  - product on `i_product` in cycle T+1+`MULT_LAT`;
  - `o_rsp_valid` / `o_rsp_product` in cycle T+2+`MULT_LAT`.
- Responses return in grant order, and there is at most one per cycle.
- Simultaneous requests: the lowest index at or after `ptr` wins. The others wait, with ready=0.
- Single persistent requester: granted every cycle.
- `i_en` deasserted mid-stream: no grants from that cycle on. Already-issued operations drain and respond on schedule.
- Reset mid-operation: all in-flight operations are discarded. No response is produced for them, even when the reset lasts only 1 cycle. `ptr` returns to 0.
- `i_rst` and `i_req_valid` asserted in the same cycle: no grant.

## Test plan

- **Single request.** `MULT_LAT`=2, bench multiplier model. Requester 2 requests A=0x0003, B=0x0005, flags 0/0, at T → `o_req_ready`=4'b0100 at T; `o_multa`=0x0003 at T+1; `o_rsp_valid`=4'b0100 and `o_rsp_product`=0x0000000F at T+4; `o_busy` high from T+1 to T+3.
- **All four requesting, held for 4 cycles from reset.** Grants go 0,1,2,3 on consecutive cycles. Responses arrive one-hot in order 0,1,2,3 in cycles T+4..T+7, each with its own product.
- **Fairness.** Requesters 1 and 3 request continuously for 8 cycles → grants alternate 1,3,1,3,…; neither is ever granted twice in a row.
- **Enable gating.** Requester 0 is granted at T, then `i_en`=0 at T+1 → no grants while `i_en`=0; requester 0's response still appears at T+4; `o_busy` drops after it.
- **Reset mid-flight.** Grant at T, `i_rst`=1 for one cycle at T+2 → no `o_rsp_valid` at any cycle; all outputs at reset values after T+2; next grant starts from requester 0.
- **Sign flag routing.** Requester 1 issues A=0xFFFF, B=0x0002 with multa_ns=1 and multb_ns=0 → `o_multa_ns`=1 and `o_multb_ns`=0 at T+1; `o_rsp_product` equals the model result for those flags at T+4.

Source files
------------

// File: rtl/mult16x16_arb_if.sv
// mult16x16_arb_if: request/response and multiplier-side bus for mult16x16_arb
//   slave  : the arbiter (takes requests and the product, drives grants, operands, responses)
//   master : the clients plus the multiplier (drive requests and the product)
interface mult16x16_arb_if #(
   parameter int NREQ = 4
);
   logic                 i_en;
   logic [NREQ-1:0]      i_req_valid;
   logic [NREQ-1:0]      o_req_ready;
   logic [NREQ*16-1:0]   i_req_multa;
   logic [NREQ*16-1:0]   i_req_multb;
   logic [NREQ-1:0]      i_req_multa_ns;
   logic [NREQ-1:0]      i_req_multb_ns;
   logic [15:0]          o_multa;
   logic [15:0]          o_multb;
   logic                 o_multa_ns;
   logic                 o_multb_ns;
   logic [31:0]          i_product;
   logic [NREQ-1:0]      o_rsp_valid;
   logic [31:0]          o_rsp_product;
   logic                 o_busy;
   modport slave (
      input  i_en, i_req_valid, i_req_multa, i_req_multb, i_req_multa_ns, i_req_multb_ns, i_product,
      output o_req_ready, o_multa, o_multb, o_multa_ns, o_multb_ns, o_rsp_valid, o_rsp_product, o_busy
   );
   modport master (
      output i_en, i_req_valid, i_req_multa, i_req_multb, i_req_multa_ns, i_req_multb_ns, i_product,
      input  o_req_ready, o_multa, o_multb, o_multa_ns, o_multb_ns, o_rsp_valid, o_rsp_product, o_busy
   );
endinterface

// File: rtl/mult16x16_arb.sv
// mult16x16_arb: round-robin sharing of one fixed-latency 16x16 multiplier among NREQ requesters
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : requests (valid/ready, operands, sign flags), multiplier operands/product,
//                  one-hot responses with shared product, grant enable and busy
module mult16x16_arb #(
   parameter int NREQ     = 4,
   parameter int MULT_LAT = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   mult16x16_arb_if.slave        bus
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
   logic [TW-1:0]                 r_ptr;
   logic                          r_v0;
   logic [TW-1:0]                 r_t0;
   logic [15:0]                   r_multa;
   logic [15:0]                   r_multb;
   logic                          r_multa_ns;
   logic                          r_multb_ns;
   logic [MULT_LAT-1:0]           r_pv;
   logic [MULT_LAT-1:0][TW-1:0]   r_pt;
   logic [NREQ-1:0]               r_rsp_valid;
   logic [31:0]                   r_rsp_product;
   logic                          w_found;
   logic [TW-1:0]                 w_gnt_idx;
   logic [TW-1:0]                 w_cand;
   logic [NREQ-1:0]               w_gnt;
   logic [15:0]                   w_a [NREQ];
   logic [15:0]                   w_b [NREQ];
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign w_a[g] = bus.i_req_multa[16*g +: 16];
      assign w_b[g] = bus.i_req_multb[16*g +: 16];
   end
   // Scan from r_ptr upward with wrap; reset and i_en gate every grant.
   always_comb begin
      w_found   = 1'b0;
      w_gnt_idx = r_ptr;
      w_cand    = r_ptr;
      for (int i = 0; i < NREQ; i++) begin
         w_cand = TW'((int'(r_ptr) + i) % NREQ);
         if (!w_found && bus.i_req_valid[w_cand] && bus.i_en && !i_rst) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
      w_gnt = w_found ? (NREQ'(1) << w_gnt_idx) : '0;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr      <= '0;
         r_v0       <= 1'b0;
         r_t0       <= '0;
         r_multa    <= '0;
         r_multb    <= '0;
         r_multa_ns <= 1'b0;
         r_multb_ns <= 1'b0;
      end else begin
         r_v0 <= w_found;
         if (w_found) begin
            r_ptr      <= (w_gnt_idx == TW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_t0       <= w_gnt_idx;
            r_multa    <= w_a[w_gnt_idx];
            r_multb    <= w_b[w_gnt_idx];
            r_multa_ns <= bus.i_req_multa_ns[w_gnt_idx];
            r_multb_ns <= bus.i_req_multb_ns[w_gnt_idx];
         end
      end
   end
   // Tag pipeline: stage MULT_LAT-1 lines up with the product of the issued operands.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pv          <= '0;
         r_pt          <= '0;
         r_rsp_valid   <= '0;
         r_rsp_product <= '0;
      end else begin
         for (int k = MULT_LAT - 1; k > 0; k--) begin
            r_pv[k] <= r_pv[k-1];
            r_pt[k] <= r_pt[k-1];
         end
         r_pv[0]     <= r_v0;
         r_pt[0]     <= r_t0;
         r_rsp_valid <= r_pv[MULT_LAT-1] ? (NREQ'(1) << r_pt[MULT_LAT-1]) : '0;
         if (r_pv[MULT_LAT-1]) r_rsp_product <= bus.i_product;
      end
   end
   assign bus.o_req_ready   = w_gnt;
   assign bus.o_multa       = r_multa;
   assign bus.o_multb       = r_multb;
   assign bus.o_multa_ns    = r_multa_ns;
   assign bus.o_multb_ns    = r_multb_ns;
   assign bus.o_rsp_valid   = r_rsp_valid;
   assign bus.o_rsp_product = r_rsp_product;
   assign bus.o_busy        = r_v0 | (|r_pv);
endmodule

// File: tb/tb_mult16x16_arb.sv
// tb_mult16x16_arb: directed checks of mult16x16_arb with a 2-cycle multiplier model (ns=1 means signed operand)
module tb_mult16x16_arb;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] m1 = '0;
   logic [31:0] m2 = '0;
   logic [31:0] exp_p [4];
   mult16x16_arb_if #(.NREQ(4)) bus ();
   mult16x16_arb #(.NREQ(4), .MULT_LAT(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b, input logic an, input logic bn);
      logic [31:0] ea, eb;
      ea = an ? {{16{a[15]}}, a} : {16'b0, a};
      eb = bn ? {{16{b[15]}}, b} : {16'b0, b};
      return ea * eb;
   endfunction
   always @(posedge clk) begin
      m1 <= mul(bus.o_multa, bus.o_multb, bus.o_multa_ns, bus.o_multb_ns);
      m2 <= m1;
   end
   assign bus.i_product = m2;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic set_req(input int k, input logic [15:0] a, input logic [15:0] b, input logic an, input logic bn);
      bus.i_req_multa[16*k +: 16] = a;
      bus.i_req_multb[16*k +: 16] = b;
      bus.i_req_multa_ns[k] = an;
      bus.i_req_multb_ns[k] = bn;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      bus.i_req_valid = '0;
      step();
      step();
      rst = 1'b0;
   endtask
   initial begin
      bus.i_en = 1'b1;
      bus.i_req_valid = '0;
      bus.i_req_multa = '0;
      bus.i_req_multb = '0;
      bus.i_req_multa_ns = '0;
      bus.i_req_multb_ns = '0;
      step();
      do_reset();
      @(negedge clk);
      check("rst_ready", 32'(bus.o_req_ready), 32'h0);
      check("rst_multa", 32'(bus.o_multa), 32'h0);
      check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'h0);
      check("rst_rsp_product", bus.o_rsp_product, 32'h0);
      check("rst_busy", 32'(bus.o_busy), 32'h0);
      // single request from requester 2
      step();
      set_req(2, 16'h0003, 16'h0005, 1'b0, 1'b0);
      bus.i_req_valid = 4'b0100;
      @(negedge clk);
      check("single_ready", 32'(bus.o_req_ready), 32'h4);
      step();
      bus.i_req_valid = '0;
      @(negedge clk);
      check("single_multa", 32'(bus.o_multa), 32'h3);
      check("single_busy1", 32'(bus.o_busy), 32'h1);
      step();
      @(negedge clk);
      check("single_busy2", 32'(bus.o_busy), 32'h1);
      check("single_no_rsp", 32'(bus.o_rsp_valid), 32'h0);
      step();
      @(negedge clk);
      check("single_busy3", 32'(bus.o_busy), 32'h1);
      step();
      @(negedge clk);
      check("single_rsp_valid", 32'(bus.o_rsp_valid), 32'h4);
      check("single_rsp_product", bus.o_rsp_product, 32'h0000000F);
      check("single_busy4", 32'(bus.o_busy), 32'h0);
      // all four requesting from reset
      step();
      do_reset();
      set_req(0, 16'h0002, 16'h0003, 1'b0, 1'b0);
      set_req(1, 16'h0010, 16'h0010, 1'b0, 1'b0);
      set_req(2, 16'h1234, 16'h0002, 1'b0, 1'b0);
      set_req(3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      exp_p[0] = 32'h00000006;
      exp_p[1] = 32'h00000100;
      exp_p[2] = 32'h00002468;
      exp_p[3] = 32'hFFFE0001;
      for (int c = 0; c < 8; c++) begin
         bus.i_req_valid = (c < 4) ? 4'hF : 4'h0;
         @(negedge clk);
         if (c < 4) check($sformatf("all4_ready%0d", c), 32'(bus.o_req_ready), 32'(4'b0001 << c));
         else begin
            check($sformatf("all4_rsp_valid%0d", c - 4), 32'(bus.o_rsp_valid), 32'(4'b0001 << (c - 4)));
            check($sformatf("all4_rsp_product%0d", c - 4), bus.o_rsp_product, exp_p[c-4]);
         end
         step();
      end
      // fairness between requesters 1 and 3
      for (int c = 0; c < 8; c++) begin
         bus.i_req_valid = 4'b1010;
         @(negedge clk);
         check($sformatf("fair_ready%0d", c), 32'(bus.o_req_ready), (c % 2 == 0) ? 32'h2 : 32'h8);
         step();
      end
      bus.i_req_valid = '0;
      repeat (5) step();
      // enable gating
      set_req(0, 16'h0007, 16'h0009, 1'b0, 1'b0);
      bus.i_req_valid = 4'b0001;
      @(negedge clk);
      check("en_ready_grant", 32'(bus.o_req_ready), 32'h1);
      step();
      bus.i_en = 1'b0;
      for (int c = 1; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("en_blocked%0d", c), 32'(bus.o_req_ready), 32'h0);
         step();
      end
      @(negedge clk);
      check("en_rsp_valid", 32'(bus.o_rsp_valid), 32'h1);
      check("en_rsp_product", bus.o_rsp_product, 32'h0000003F);
      check("en_busy_after", 32'(bus.o_busy), 32'h0);
      check("en_still_blocked", 32'(bus.o_req_ready), 32'h0);
      step();
      bus.i_en = 1'b1;
      bus.i_req_valid = '0;
      repeat (3) step();
      // reset mid-flight
      set_req(2, 16'h0011, 16'h0022, 1'b0, 1'b0);
      bus.i_req_valid = 4'b0100;
      @(negedge clk);
      check("rstmid_grant", 32'(bus.o_req_ready), 32'h4);
      step();
      bus.i_req_valid = '0;
      step();
      rst = 1'b1;
      bus.i_req_valid = 4'b0001;
      @(negedge clk);
      check("rstmid_ready_in_rst", 32'(bus.o_req_ready), 32'h0);
      step();
      rst = 1'b0;
      bus.i_req_valid = '0;
      @(negedge clk);
      check("rstmid_multa", 32'(bus.o_multa), 32'h0);
      check("rstmid_busy", 32'(bus.o_busy), 32'h0);
      for (int c = 3; c < 7; c++) begin
         @(negedge clk);
         check($sformatf("rstmid_no_rsp%0d", c), 32'(bus.o_rsp_valid), 32'h0);
         step();
      end
      bus.i_req_valid = 4'hF;
      @(negedge clk);
      check("rstmid_ptr0", 32'(bus.o_req_ready), 32'h1);
      step();
      bus.i_req_valid = '0;
      repeat (5) step();
      // sign flag routing, requester 1 (pointer now at 1)
      set_req(1, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
      bus.i_req_valid = 4'b0010;
      @(negedge clk);
      check("sign_ready", 32'(bus.o_req_ready), 32'h2);
      step();
      bus.i_req_valid = '0;
      @(negedge clk);
      check("sign_multa", 32'(bus.o_multa), 32'hFFFF);
      check("sign_multa_ns", 32'(bus.o_multa_ns), 32'h1);
      check("sign_multb_ns", 32'(bus.o_multb_ns), 32'h0);
      step();
      step();
      step();
      @(negedge clk);
      check("sign_rsp_valid", 32'(bus.o_rsp_valid), 32'h2);
      check("sign_rsp_product", bus.o_rsp_product, 32'hFFFFFFFE);
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
